// File: rtl/masked_rca_pipe.sv
// masked_rca_pipe: first-order Boolean-masked ripple-carry adder/subtractor.
// One bit per pipeline stage. Each carry is built from two DOM AND gadgets
// whose registered terms form the stage register. All data travels as two
// XOR shares, and the shares are kept apart through every skew line.
module masked_rca_pipe #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a0,
    input  logic [WIDTH-1:0]   a1,
    input  logic [WIDTH-1:0]   b0,
    input  logic [WIDTH-1:0]   b1,
    input  logic               c0,
    input  logic               c1,
    input  logic               sub,
    input  logic [2*WIDTH-1:0] rnd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     s0,
    output logic [WIDTH:0]     s1
);

    // The pipeline is a rigid shift: every register advances together or holds.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Operand shares as seen by stage i (bit i, delayed by i cycles).
    logic [WIDTH-1:0] pa0, pa1, pb0, pb1;
    // Carry shares entering stage i. Index WIDTH is the carry-out.
    logic [WIDTH:0]   cy0, cy1;
    // Sum shares at the end of their delay lines.
    logic [WIDTH-1:0] so0, so1;
    logic             hi0, hi1;
    logic [WIDTH:0]   vld;

    // Subtraction folds into addition: invert share 0 of B and of the carry-in.
    assign cy0[0] = c0 ^ sub;
    assign cy1[0] = c1;

    // The valid bit travels alongside the data so that bubbles stay in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[WIDTH-1:0], in_valid};
        end
    end

    assign out_valid = vld[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic p0, p1;
        logic gi0, gx0, gi1, gx1;
        logic ti0, tx0, ti1, tx1;
        logic [1:0] sum_line [WIDTH-i+1];

        if (i == 0) begin : g_direct
            assign pa0[0] = a0[0];
            assign pa1[0] = a1[0];
            assign pb0[0] = b0[0] ^ sub;
            assign pb1[0] = b1[0];
        end else begin : g_skew
            // Entry layout: {a0, a1, b0 (mode-mapped), b1}.
            logic [3:0] op_line [i];

            // Delay operand bit i by i cycles so that it meets carry_i.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < i; k++) op_line[k] <= '0;
                end else if (en) begin
                    op_line[0] <= {a0[i], a1[i], b0[i] ^ sub, b1[i]};
                    for (int k = 1; k < i; k++) op_line[k] <= op_line[k-1];
                end
            end

            assign pa0[i] = op_line[i-1][3];
            assign pa1[i] = op_line[i-1][2];
            assign pb0[i] = op_line[i-1][1];
            assign pb1[i] = op_line[i-1][0];
        end

        assign p0 = pa0[i] ^ pb0[i];
        assign p1 = pa1[i] ^ pb1[i];

        // DOM gadgets g = a&b (rnd[2i]) and t = p&carry (rnd[2i+1]); each
        // cross-domain term is refreshed and registered before recombination.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                {gi0, gx0, gi1, gx1} <= '0;
                {ti0, tx0, ti1, tx1} <= '0;
            end else if (en) begin
                gi0 <= pa0[i] & pb0[i];
                gx0 <= (pa0[i] & pb1[i]) ^ rnd[2*i];
                gi1 <= pa1[i] & pb1[i];
                gx1 <= (pa1[i] & pb0[i]) ^ rnd[2*i];
                ti0 <= p0 & cy0[i];
                tx0 <= (p0 & cy1[i]) ^ rnd[2*i+1];
                ti1 <= p1 & cy1[i];
                tx1 <= (p1 & cy0[i]) ^ rnd[2*i+1];
            end
        end

        assign cy0[i+1] = gi0 ^ gx0 ^ ti0 ^ tx0;
        assign cy1[i+1] = gi1 ^ gx1 ^ ti1 ^ tx1;

        // Carry sum bit i from stage i to the output register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int k = 0; k <= WIDTH - i; k++) sum_line[k] <= '0;
            end else if (en) begin
                sum_line[0] <= {p0 ^ cy0[i], p1 ^ cy1[i]};
                for (int k = 1; k <= WIDTH - i; k++) sum_line[k] <= sum_line[k-1];
            end
        end

        assign so0[i] = sum_line[WIDTH-i][1];
        assign so1[i] = sum_line[WIDTH-i][0];
    end

    // Carry-out register, aligned with the last element of each sum line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi0 <= 1'b0;
            hi1 <= 1'b0;
        end else if (en) begin
            hi0 <= cy0[WIDTH];
            hi1 <= cy1[WIDTH];
        end
    end

    assign s0 = {hi0, so0};
    assign s1 = {hi1, so1};

endmodule

// File: tb/tb_masked_rca_pipe.sv
// Randomised bench for masked_rca_pipe against a plain-arithmetic scoreboard.
module tb_masked_rca_pipe;
    localparam int W  = 4;
    localparam int RW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a0, a1, b0, b1;
    logic          c0, c1, sub;
    logic [RW-1:0] rnd;
    logic [W:0]    s0, s1;

    masked_rca_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0), .c1(c1), .sub(sub),
        .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
        .s0(s0), .s1(s1)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] cur_a, cur_b;
    logic         cur_c, cur_sub;
    logic [W:0]   exp_q [$];
    logic [W:0]   got_log [$];
    int           cyc_log [$];
    logic [W:0]   last_s, last_s0;
    int           n_push, n_pop;
    logic         hold_pend;
    logic         held_v;
    logic [W:0]   held_s0, held_s1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Unmasked reference: add gives A+B+C, subtract gives A+~B+(1^C), both WIDTH+1 bits.
    function automatic logic [W:0] ref_s(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
        int unsigned bv, cv, tot;
        bv  = s ? ((1 << W) - 1 - int'(b)) : int'(b);
        cv  = s ? (c ? 0 : 1) : (c ? 1 : 0);
        tot = int'(a) + bv + cv;
        return tot[W:0];
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s, input logic [W-1:0] am,
                         input logic [W-1:0] bm, input logic cm);
        in_valid = v;
        cur_a = a; cur_b = b; cur_c = c; cur_sub = s;
        a0 = am; a1 = am ^ a;
        b0 = bm; b1 = bm ^ b;
        c0 = cm; c1 = cm ^ c;
        sub = s;
        rnd = RW'($urandom);
    endtask

    task automatic drive_rand(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic c, input logic s);
        drive(v, a, b, c, s, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    task automatic idle();
        drive_rand(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    task automatic beat_rand();
        drive_rand(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Called just after inputs change at a falling edge; observes the
    // handshakes that the next rising edge will perform.
    task automatic sample();
        #1;
        if (hold_pend) begin
            check("hold_valid", out_valid, held_v);
            check("hold_s0", s0, held_s0);
            check("hold_s1", s1, held_s1);
        end
        check("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
            last_s  = s0 ^ s1;
            last_s0 = s0;
            got_log.push_back(s0 ^ s1);
            cyc_log.push_back(cyc);
            n_pop++;
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else check("result", s0 ^ s1, exp_q.pop_front());
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(ref_s(cur_a, cur_b, cur_c, cur_sub));
            n_push++;
        end
        hold_pend = out_valid && !out_ready;
        held_v = out_valid; held_s0 = s0; held_s1 = s1;
    endtask

    task automatic step();
        sample();
        @(negedge clk);
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 40) begin
            idle();
            step();
            budget++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic clear_logs();
        got_log.delete();
        cyc_log.delete();
        n_push = 0;
        n_pop  = 0;
    endtask

    logic [W:0] s0_run [4];
    logic       s0_diff;

    initial begin
        hold_pend = 1'b0;
        clear_logs();
        last_s = '0; last_s0 = '0;
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_s0", s0, 0);
        check("rst_s1", s1, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Add with latency: a=(3,6) b=(A,3) c=(1,0).
        drive(1'b1, 4'h5, 4'h9, 1'b1, 1'b0, 4'h3, 4'hA, 1'b1);
        step();
        for (int n = 1; n <= W + 1; n++) begin
            idle();
            sample();
            check("latency_valid", out_valid, (n == W + 1) ? 1 : 0);
            @(negedge clk);
        end
        check("add_result", last_s, 'h0F);

        // Subtract without and with borrow, back to back.
        clear_logs();
        drive(1'b1, 4'h9, 4'h5, 1'b0, 1'b1, 4'h9, 4'h0, 1'b0);
        step();
        drive_rand(1'b1, 4'h3, 4'h5, 1'b0, 1'b1);
        step();
        drain();
        check("sub_count", got_log.size(), 2);
        check("sub_no_borrow", got_log[0], 'h14);
        check("sub_borrow", got_log[1], 'h0E);

        // Overflow and back-to-back beats.
        clear_logs();
        drive_rand(1'b1, 4'hF, 4'hF, 1'b1, 1'b0); step();
        drive_rand(1'b1, 4'h0, 4'h0, 1'b0, 1'b0); step();
        drive_rand(1'b1, 4'h8, 4'h8, 1'b0, 1'b0); step();
        drain();
        check("ovf_count", got_log.size(), 3);
        check("ovf_r0", got_log[0], 'h1F);
        check("ovf_r1", got_log[1], 'h00);
        check("ovf_r2", got_log[2], 'h10);
        check("ovf_consec1", cyc_log[1] - cyc_log[0], 1);
        check("ovf_consec2", cyc_log[2] - cyc_log[1], 1);

        // Backpressure: five stalled cycles while the source keeps offering beats.
        clear_logs();
        for (int n = 0; n < 14; n++) begin
            beat_rand();
            out_ready = !(n >= 6 && n <= 10);
            sample();
            if (n >= 6 && n <= 10) check("bp_in_ready_low", in_ready, 0);
            @(negedge clk);
        end
        drain();
        check("bp_no_loss", n_pop, n_push);

        // Masking: same values, different sharings and randomness.
        for (int r = 0; r < 4; r++) begin
            drive(1'b1, 4'hB, 4'h6, 1'b1, 1'b0, W'(r), 4'h5, 1'b0);
            step();
            drain();
            check("mask_result", last_s, 'h12);
            s0_run[r] = last_s0;
        end
        s0_diff = 1'b0;
        for (int r = 1; r < 4; r++) if (s0_run[r] != s0_run[0]) s0_diff = 1'b1;
        check("mask_s0_differs", s0_diff, 1);

        // Asynchronous reset mid-stream.
        out_ready = 1'b1;
        for (int n = 0; n < W + 3; n++) begin
            beat_rand();
            step();
        end
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_s0", s0, 0);
        check("arst_s1", s1, 0);
        check("arst_in_ready", in_ready, 1);
        exp_q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < W + 3; n++) begin
            idle();
            sample();
            check("no_stale", out_valid, 0);
            @(negedge clk);
        end
        drive_rand(1'b1, 4'h7, 4'h2, 1'b1, 1'b1);
        step();
        drain();
        check("post_rst_result", last_s, ref_s(4'h7, 4'h2, 1'b1, 1'b1));

        // Random traffic with random backpressure and bubbles.
        clear_logs();
        for (int n = 0; n < 300; n++) begin
            drive_rand(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
                       1'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        check("rand_no_loss", n_pop, n_push);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/masked_rca_pipe.md
# masked_rca_pipe

Parametrised, first-order Boolean-masked, bit-serial-pipelined ripple-carry adder/subtractor with a valid/ready handshake. Operands, carry-in and result are each carried as two XOR shares. Every carry is computed with domain-oriented-masking (DOM) AND gadgets fed by fresh randomness, one pipeline stage per bit. It is the generalised successor of the fixed 4-bit masked pipelined RCA: width is a parameter, and it adds an add/subtract mode, masked carry-in and backpressure.

## Interface
- WIDTH, 4: operand width in bits; ≥ 2.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- a0, a1  in  WIDTH  shares of operand A (A = a0^a1)
- b0, b1  in  WIDTH  shares of operand B
- c0, c1  in  1  shares of carry-in/borrow-in C
- sub  in  1  0 = add, 1 = subtract; unmasked, per beat
- rnd  in  2*WIDTH  fresh randomness; bits [2i+1:2i] belong to bit-stage i
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- s0, s1  out  WIDTH+1  shares of result S (S = s0^s1)

## Operation
- Arithmetic (unmasked view):
  - Add: S = A + B + C, WIDTH+1 bits. S[WIDTH] is carry-out.
  - Subtract: S = A + ~B + (1^C) = A − B − C mod 2^WIDTH. S[WIDTH] = 1 means no borrow.
- Mode mapping at capture:
  - b0 is inverted when sub = 1; b1 is never inverted.
  - Carry-in shares become (c0^sub, c1).
  - No unmasked value of A, B, C or S is ever formed.
- Stage i (0..WIDTH-1), using share-wise XOR:
  - p = a_i^b_i.
  - sum_i shares = p ^ carry_i shares.
  - g = DOM-AND(a_i, b_i) with rnd[2i].
  - t = DOM-AND(p, carry_i) with rnd[2i+1].
  - carry_{i+1} shares = g ^ t.
- DOM-AND(x, y, r):
  - z0 = x0·y0 ^ reg(x0·y1 ^ r).
  - z1 = x1·y1 ^ reg(x1·y0 ^ r).
  - Each cross-domain term is registered before recombination; this is the stage register.
- Skew lines:
  - Unprocessed operand bits are delayed so bit i reaches stage i together with carry_i.
  - Completed sum bits are delayed to the output.
  - All skew lines stay per share; shares are never XORed together.
- Randomness: rnd is sampled only in cycles where the pipeline advances. Each bit of rnd is used by exactly one gadget per beat.

## Timing
- Pipeline enable: en = !out_valid || out_ready. in_ready = en.
- Stall behaviour:
  - The whole pipeline is a rigid shift; it holds when en = 0.
  - Bubbles are not compressed.
  - A beat is accepted when in_valid && in_ready at a rising edge.
- Latency:
  - A beat accepted at edge k gives out_valid = 1, with s0/s1 valid, after edge k+WIDTH.
  - Throughput is one beat per cycle when out_ready stays high.
- Output holding: s0, s1 and out_valid hold stable while out_valid && !out_ready.
- Simultaneous events:
  - Output handshake and input acceptance in the same cycle is legal. The pipeline shifts and no beat is lost or duplicated.
  - in_valid = 0 injects a bubble. The valid bit shifts along with the data.
- Reset:
  - rst_n low, at any time and including mid-stream, clears every register to 0 immediately.
  - After reset: out_valid = 0, s0 = s1 = 0, in_ready = 1.
  - In-flight beats are discarded.
  - The first beat after rst_n rises may be accepted at the first rising edge.
- Inputs sampled while en = 0 are ignored, including rnd.

## Test plan
- Add, WIDTH = 4: a = (3, 6), b = (A, 3), c = (1, 0), sub = 0, rnd = random, out_ready = 1 → after 4 edges out_valid = 1 and s0^s1 = 0x0F.
- Subtract with carry-out: a = (9, 0), b = (0, 5), c = (0, 0), sub = 1 → s0^s1 = 0x14. Then A = 3, B = 5, sub = 1 → 0x0E, i.e. S[4] = 0, borrow.
- Overflow and back-to-back:
  - Beats (F+F+1), (0+0+0), (8+8+0) on consecutive cycles → results 0x1F, 0x00, 0x10 on three consecutive cycles.
- Backpressure:
  - Hold out_ready = 0 for 5 cycles while streaming → in_ready drops.
  - Outputs and shares stay frozen.
  - After release, all beats emerge in order with no loss or duplication.
- Masking: repeat one beat with two different rnd streams and different input sharings of the same values → identical s0^s1. The s0 values differ in at least one run.
- Reset mid-stream: pulse rst_n low asynchronously, between edges, with 3 beats in flight → out_valid = 0 and s0 = s1 = 0 immediately. No stale beat appears afterwards.
